// File: rtl/imem_boot_responder.sv
// -----------------------------------------------------------------------------
// imem_boot_responder
//
// Responder end of the processor's instruction-memory interface. This is a
// word-addressed instruction store. It is filled at boot through a valid/ready
// load stream, and after that it serves fetches combinationally. Until boot
// completes, and for any unloaded or illegal address, the fetch returns
// NOP_INST. That lets the processor leave reset before the program is resident.
//
// Parameters
//   NUM_WORDS  store depth in 32-bit words (power of 2, >= 2)
//   BASE_ADDR  byte address of word 0 (processor reset vector)
//   NOP_INST   word returned when no valid instruction is available
//
// Ports
//   clk            clock, all state updates on rising edge
//   rst            asynchronous active-high reset
//   imemreq_val    fetch request valid
//   imemreq_addr   fetch byte address
//   imemresp_data  fetched instruction, same cycle as request
//   load_val       load word valid
//   load_data      load word
//   load_last      qualifies load_val: final program word
//   load_rdy       store is accepting load words (LOAD state)
//   boot_done      program loaded, fetches served from the store (RUN state)
//   err_oob        sticky: a RUN-state fetch hit an illegal address
//   req_count      saturating count of RUN-state fetches
// -----------------------------------------------------------------------------
module imem_boot_responder #(
  parameter int unsigned NUM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0200,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imemreq_val,
  input  logic [31:0] imemreq_addr,
  output logic [31:0] imemresp_data,
  input  logic        load_val,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_rdy,
  output logic        boot_done,
  output logic        err_oob,
  output logic [31:0] req_count
);

  localparam int unsigned AW   = $clog2(NUM_WORDS);
  localparam logic [31:0] SPAN = 32'(4 * NUM_WORDS);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   loaded;
  logic          err_q;
  logic [31:0]   req_cnt;
  logic [31:0]   mem [NUM_WORDS];

  logic          load_fire;
  logic          load_end;
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          legal;
  logic          hit;

  assign load_rdy  = (state == ST_LOAD);
  assign boot_done = (state == ST_RUN);
  assign err_oob   = err_q;
  assign req_count = req_cnt;

  assign load_fire = load_val && load_rdy;
  assign load_end  = load_last || (wr_ptr == AW'(NUM_WORDS - 1));

  // Address decode. The range check on the full 32-bit offset guarantees
  // that the upper index bits are zero. Because of that, only the low AW bits
  // are needed to index the store.
  always_comb begin
    off   = imemreq_addr - BASE_ADDR;
    idx   = off[AW+1:2];
    legal = (imemreq_addr >= BASE_ADDR) && (off < SPAN) &&
            (imemreq_addr[1:0] == 2'b00);
    hit   = boot_done && imemreq_val && legal && ({1'b0, idx} < loaded);
  end

  always_comb begin
    imemresp_data = NOP_INST;
    if (hit) begin
      imemresp_data = mem[idx];
    end
  end

  // The store has no reset. Stale contents are masked by 'loaded'.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem[wr_ptr] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_LOAD;
      wr_ptr <= '0;
      loaded <= '0;
    end else if (load_fire) begin
      loaded <= {1'b0, wr_ptr} + 1'b1;
      // On the final word, wr_ptr is left as it is so that it never wraps.
      if (load_end) begin
        state <= ST_RUN;
      end else begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q   <= 1'b0;
      req_cnt <= '0;
    end else if (boot_done && imemreq_val) begin
      if (req_cnt != '1) begin
        req_cnt <= req_cnt + 1'b1;
      end
      if (!legal) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_responder.sv
module tb_imem_boot_responder;

  localparam int unsigned NW   = 16;
  localparam logic [31:0] BASE = 32'h0000_0200;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imemreq_val;
  logic [31:0] imemreq_addr;
  logic [31:0] imemresp_data;
  logic        load_val;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_rdy;
  logic        boot_done;
  logic        err_oob;
  logic [31:0] req_count;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  imem_boot_responder #(
    .NUM_WORDS(NW),
    .BASE_ADDR(BASE),
    .NOP_INST (NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imemreq_val  (imemreq_val),
    .imemreq_addr (imemreq_addr),
    .imemresp_data(imemresp_data),
    .load_val     (load_val),
    .load_data    (load_data),
    .load_last    (load_last),
    .load_rdy     (load_rdy),
    .boot_done    (boot_done),
    .err_oob      (err_oob),
    .req_count    (req_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Advance one clock edge; inputs change 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    tick();
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    load_val  = 1'b1;
    load_data = d;
    load_last = last;
    tick();
    load_val  = 1'b0;
    load_last = 1'b0;
  endtask

  // Present one fetch, check the combinational response, then clock it.
  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp);
    imemreq_val  = 1'b1;
    imemreq_addr = a;
    #1;
    check(tag, imemresp_data, exp);
    tick();
    imemreq_val = 1'b0;
  endtask

  initial begin
    rst = 1'b1; imemreq_val = 1'b0; imemreq_addr = '0;
    load_val = 1'b0; load_data = '0; load_last = 1'b0;

    // 1: reset state, fetch held during reset and in LOAD
    imemreq_val  = 1'b1;
    imemreq_addr = 32'h200;
    #12;
    check("rst_data", imemresp_data, NOP);
    check("rst_rdy", {31'd0, load_rdy}, 32'd1);
    check("rst_boot", {31'd0, boot_done}, 32'd0);
    check("rst_cnt", req_count, 32'd0);
    check("rst_err", {31'd0, err_oob}, 32'd0);
    rst = 1'b0;
    tick(); tick();
    check("load_fetch_nop", imemresp_data, NOP);
    check("load_fetch_uncnt", req_count, 32'd0);
    imemreq_val = 1'b0;

    // 2: three-word boot, same-cycle fetch on the final load edge sees NOP
    load_word(32'h0010_0093, 1'b0);
    load_word(32'h0020_8113, 1'b0);
    imemreq_val = 1'b1; imemreq_addr = 32'h200;
    load_val = 1'b1; load_data = 32'h0000_0063; load_last = 1'b1;
    #1;
    check("last_edge_nop", imemresp_data, NOP);
    tick();
    load_val = 1'b0; load_last = 1'b0; imemreq_val = 1'b0;
    check("boot_done", {31'd0, boot_done}, 32'd1);
    check("rdy_low", {31'd0, load_rdy}, 32'd0);
    check("cnt_after_boot", req_count, 32'd0);
    fetch("f200", 32'h200, 32'h0010_0093);
    fetch("f204", 32'h204, 32'h0020_8113);
    fetch("f208", 32'h208, 32'h0000_0063);
    fetch("f20c_unloaded", 32'h20C, NOP);
    check("err_unloaded", {31'd0, err_oob}, 32'd0);
    check("cnt4", req_count, 32'd4);
    imemreq_addr = 32'h200; #1;
    check("val0_nop", imemresp_data, NOP);

    // 3: illegal addresses in RUN set err_oob, which is sticky
    do_reset();
    load_word(32'hDEAD_BEEF, 1'b1);
    fetch("f200_b", 32'h200, 32'hDEAD_BEEF);
    do_reset();
    load_word(32'hDEAD_BEEF, 1'b1);
    fetch("f1fc", 32'h1FC, NOP);
    check("err_below", {31'd0, err_oob}, 32'd1);
    fetch("f202", 32'h202, NOP);
    check("err_misalign", {31'd0, err_oob}, 32'd1);
    fetch("f_end", BASE + 4 * NW, NOP);
    check("err_above", {31'd0, err_oob}, 32'd1);
    check("cnt3", req_count, 32'd3);
    tick();
    check("err_sticky", {31'd0, err_oob}, 32'd1);

    // 4: fill the store without load_last
    do_reset();
    for (int i = 0; i < NW; i++) begin
      if (i == NW - 1) check("not_done_yet", {31'd0, boot_done}, 32'd0);
      load_word(32'hA000_0000 + 32'(i), 1'b0);
    end
    check("full_boot", {31'd0, boot_done}, 32'd1);
    check("full_rdy", {31'd0, load_rdy}, 32'd0);
    load_word(32'h0000_0BAD, 1'b0);
    fetch("f_last", BASE + 4 * (NW - 1), 32'hA000_0000 + 32'(NW - 1));
    fetch("f_first", 32'h200, 32'hA000_0000);
    check("err_full", {31'd0, err_oob}, 32'd0);

    // 5: async reset mid-load, reload masks stale words, counter saturation
    do_reset();
    load_word(32'h0000_0011, 1'b0);
    load_word(32'h0000_0022, 1'b0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_rdy", {31'd0, load_rdy}, 32'd1);
    check("arst_boot", {31'd0, boot_done}, 32'd0);
    rst = 1'b0;
    tick();
    fetch("arst_nop0", 32'h200, NOP);
    fetch("arst_nop1", 32'h200, NOP);
    load_word(32'h0000_0011, 1'b0);
    load_word(32'h0000_0022, 1'b0);
    load_word(32'h0000_0033, 1'b1);
    fetch("reload_200", 32'h200, 32'h0000_0011);
    fetch("reload_208", 32'h208, 32'h0000_0033);
    fetch("stale_masked", 32'h20C, NOP);
    check("err_reload", {31'd0, err_oob}, 32'd0);
    check("cnt_reload", req_count, 32'd3);
    force dut.req_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.req_cnt;
    #1;
    check("forced_cnt", req_count, 32'hFFFF_FFFE);
    fetch("sat_f0", 32'h200, 32'h0000_0011);
    check("sat1", req_count, 32'hFFFF_FFFF);
    fetch("sat_f1", 32'h204, 32'h0000_0022);
    check("sat2", req_count, 32'hFFFF_FFFF);
    fetch("sat_f2", 32'h208, 32'h0000_0033);
    check("sat3", req_count, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
